eth_fcs_ctrl: RTL and testbench
===============================

// Module: eth_fcs_ctrl
// PURPOSE
//  Sequences the combinational CRC-32 engine (crc32_comb) for the MAC TX path: frames a byte
//  stream, drives the engine's strt/updatecrc/data, pads short frames, and appends the 4-byte FCS.
//  Sits between the TX frame source and the GMII byte serializer; owns the only engine instance.
// PARAMETERS
//  DATALEN   8        byte width on both streams and engine data port
//  CRC_LEN   32       engine result width
//  PAD_EN    1        1: zero-pad payloads shorter than MIN_LEN before FCS; 0: never pad
//  MIN_LEN   60       minimum payload+pad bytes (excl. FCS) when PAD_EN=1
//  CNT_W     16       byte counter width (saturates at all-ones)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  s_valid      in   1        input byte valid
//  s_ready      out  1        controller accepts input byte this cycle
//  s_data       in   DATALEN  input payload byte
//  s_last       in   1        final payload byte of frame
//  m_valid      out  1        output byte valid
//  m_ready      in   1        downstream accepts output byte
//  m_data       out  DATALEN  output byte (payload, pad or FCS)
//  m_last       out  1        final FCS byte of frame
//  crc_strt     out  1        engine init pulse (1 cycle per frame)
//  crc_update   out  1        engine accumulates crc_data this cycle
//  crc_data     out  DATALEN  byte presented to engine
//  crc_result   in   CRC_LEN  engine CRC, valid 1 cycle after last crc_update
//  busy         out  1        high in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, m_valid, m_last, crc_strt, crc_update, busy = 0; m_data, crc_data = 0;
//   byte count = 0. Reset mid-frame aborts it; no FCS emitted; engine re-initialised by next frame.
//  Transfer = valid & ready on a stream. crc_update=1 exactly on cycles an output payload/pad byte
//   transfers; crc_data = m_data in those cycles. Never asserted for FCS bytes.
//  States:
//   IDLE: s_ready=0. s_valid=1 -> crc_strt=1 for this cycle, go DATA (1-cycle start latency).
//   DATA: pass-through, zero added latency: m_valid=s_valid, m_data=s_data, s_ready=m_ready.
//    Each transfer increments count (saturating). Transfer with s_last=1: if PAD_EN and count+1<MIN_LEN
//    -> PAD, else -> CRCW.
//   PAD: s_ready=0, m_valid=1, m_data=0; each transfer increments count; transfer reaching
//    count==MIN_LEN -> CRCW.
//   CRCW: 1 cycle, m_valid=0; latch fcs = ~crc_result; k=0 -> FCS.
//   FCS: m_valid=1, m_data = fcs[CRC_LEN-1-8k -: 8] (MSB byte first); m_last=1 when k==3.
//    Transfer: k++; on k==3 transfer -> IDLE, count cleared.
//  Backpressure: m_ready=0 holds m_data/m_last/state stable; no crc_update while stalled.
//  s_valid dropping mid-frame (DATA): m_valid=0, no update; frame resumes when s_valid returns.
//  Back-to-back: after m_last transfer, one IDLE cycle minimum before next frame's crc_strt.
//  Zero-length frames impossible: first accepted byte always counts; 1-byte frame valid.
//  Count saturation only affects the pad decision (saturated count never pads).
// TESTING
//  1. "123456789" (9 bytes), PAD_EN=0, m_ready=1 -> 13 bytes out, bytes 9..12 = ~golden engine
//     model CRC MSB-first, m_last only on byte 12, crc_update high 9 cycles, crc_strt 1 pulse.
//  2. 10-byte frame 0x01..0x0A, PAD_EN=1 -> 64 bytes out, bytes 10..59 = 0x00, crc_update high
//     60 cycles, FCS = ~model CRC over 60 bytes.
//  3. 64-byte frame 0x00..0x3F, m_ready toggling 1,0 each cycle and random s_valid gaps -> 68
//     bytes out, none lost/duplicated, crc_update count = 64, FCS matches model.
//  4. Two back-to-back 60-byte frames, s_valid held high -> 2nd crc_strt exactly 2 cycles after
//     1st m_last transfer (CRC-independent), both FCS correct, no pad.
//  5. rst asserted for 1 cycle during FCS byte 1 -> next cycle all outputs at reset values,
//     busy=0; following 1-byte frame (PAD_EN=0) -> 5 bytes with correct FCS.
//  6. 1-byte frame 0xFF, PAD_EN=0 -> 5 bytes out, m_last on 5th; PAD_EN=1 -> 64 bytes out.

Source files
------------

// File: rtl/eth_fcs_ctrl_if.sv
// Byte stream bundle with valid/ready handshake and end-of-frame marker.
// Used for both the payload input and the framed output of eth_fcs_ctrl.
interface eth_fcs_ctrl_if #(
   parameter int DATALEN = 8
);
   logic               valid;
   logic               ready;
   logic               last;
   logic [DATALEN-1:0] data;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/eth_fcs_ctrl.sv
// TX frame sequencer for an external combinational CRC-32 engine:
// passes payload, zero-pads short frames and appends the FCS MSB byte first.
module eth_fcs_ctrl #(
   parameter int DATALEN = 8,
   parameter int CRC_LEN = 32,
   parameter bit PAD_EN  = 1'b1,
   parameter int MIN_LEN = 60,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   eth_fcs_ctrl_if.slave      s,
   eth_fcs_ctrl_if.master     m,
   output logic               crc_strt,
   output logic               crc_update,
   output logic [DATALEN-1:0] crc_data,
   input  logic [CRC_LEN-1:0] crc_result,
   output logic               busy
);
   localparam int NB = CRC_LEN / DATALEN;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NB - 1);
   localparam logic [CNT_W:0] MINL = (CNT_W + 1)'(MIN_LEN);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PAD,
      CRCW,
      FCS
   } state_t;

   state_t state, state_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [KW-1:0]      k, k_n;
   logic [CRC_LEN-1:0] fcs, fcs_n;
   logic               hold, hold_n;
   logic [CNT_W:0]     cnt_inc;
   logic               sat;

   assign cnt_inc = {1'b0, count} + (CNT_W + 1)'(1);
   assign sat     = &count;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         k     <= '0;
         fcs   <= '0;
         hold  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         k     <= k_n;
         fcs   <= fcs_n;
         hold  <= hold_n;
      end
   end

   always_comb begin
      state_n    = state;
      count_n    = count;
      k_n        = k;
      fcs_n      = fcs;
      hold_n     = 1'b0;
      s.ready    = 1'b0;
      m.valid    = 1'b0;
      m.data     = '0;
      m.last     = 1'b0;
      crc_strt   = 1'b0;
      crc_update = 1'b0;
      crc_data   = '0;
      unique case (state)
         IDLE: begin
            // hold enforces one dead cycle between frames
            if (!hold && s.valid) begin
               crc_strt = 1'b1;
               state_n  = DATA;
            end
         end
         DATA: begin
            m.valid = s.valid;
            m.data  = s.data;
            s.ready = m.ready;
            if (s.valid && m.ready) begin
               crc_update = 1'b1;
               crc_data   = s.data;
               if (!sat) count_n = cnt_inc[CNT_W-1:0];
               if (s.last) begin
                  if (PAD_EN && !sat && cnt_inc < MINL) state_n = PAD;
                  else state_n = CRCW;
               end
            end
         end
         PAD: begin
            m.valid = 1'b1;
            if (m.ready) begin
               crc_update = 1'b1;
               count_n    = cnt_inc[CNT_W-1:0];
               if (cnt_inc == MINL) state_n = CRCW;
            end
         end
         CRCW: begin
            fcs_n   = ~crc_result;
            k_n     = '0;
            state_n = FCS;
         end
         FCS: begin
            m.valid = 1'b1;
            m.data  = fcs[CRC_LEN-1 -: DATALEN];
            m.last  = (k == KLAST);
            if (m.ready) begin
               fcs_n = fcs << DATALEN;
               k_n   = k + KW'(1);
               if (k == KLAST) begin
                  state_n = IDLE;
                  count_n = '0;
                  hold_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_eth_fcs_ctrl.sv
// Directed bench for eth_fcs_ctrl: one instance without padding, one with.
// A behavioural reflected CRC-32 engine sits beside each instance.
module tb_eth_fcs_ctrl;
   typedef logic [7:0] bq_t[$];

   typedef struct {
      int d;
      int len;
      int first;
      bit gaps;
      bit tog;
      int exp_len;
      int exp_upd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sv, sl, mr;
   logic [1:0] sr, mv, ml, strt, upd, busy;
   logic [7:0] sd[2], md[2], cd[2];
   logic [31:0] eng0, eng1;

   int n_checks = 0;
   int n_fail   = 0;

   bq_t outq, lastq, expq, explast, dq, lq;
   int  strt_cyc[$], last_cyc[$];
   int  upd_cnt, upd_bad, exp_upd;
   vec_t vt[8];

   always #5 clk = ~clk;

   eth_fcs_ctrl_if #(.DATALEN(8)) s0 ();
   eth_fcs_ctrl_if #(.DATALEN(8)) m0 ();
   eth_fcs_ctrl_if #(.DATALEN(8)) s1 ();
   eth_fcs_ctrl_if #(.DATALEN(8)) m1 ();

   assign s0.valid = sv[0];
   assign s0.data  = sd[0];
   assign s0.last  = sl[0];
   assign m0.ready = mr[0];
   assign sr[0]    = s0.ready;
   assign mv[0]    = m0.valid;
   assign md[0]    = m0.data;
   assign ml[0]    = m0.last;
   assign s1.valid = sv[1];
   assign s1.data  = sd[1];
   assign s1.last  = sl[1];
   assign m1.ready = mr[1];
   assign sr[1]    = s1.ready;
   assign mv[1]    = m1.valid;
   assign md[1]    = m1.data;
   assign ml[1]    = m1.last;

   eth_fcs_ctrl #(.PAD_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .s(s0), .m(m0),
      .crc_strt(strt[0]), .crc_update(upd[0]),
      .crc_data(cd[0]), .crc_result(eng0), .busy(busy[0])
   );

   eth_fcs_ctrl #(.PAD_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .s(s1), .m(m1),
      .crc_strt(strt[1]), .crc_update(upd[1]),
      .crc_data(cd[1]), .crc_result(eng1), .busy(busy[1])
   );

   function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] b);
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   always @(posedge clk) begin
      if (rst || strt[0]) eng0 <= 32'hFFFFFFFF;
      else if (upd[0]) eng0 <= crc_step(eng0, cd[0]);
      if (rst || strt[1]) eng1 <= 32'hFFFFFFFF;
      else if (upd[1]) eng1 <= crc_step(eng1, cd[1]);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_frame(input int d, input bq_t pl);
      bq_t p;
      logic [31:0] c;
      p = pl;
      c = 32'hFFFFFFFF;
      if (d == 1) while (p.size() < 60) p.push_back(8'h00);
      foreach (p[j]) begin
         c = crc_step(c, p[j]);
         expq.push_back(p[j]);
         explast.push_back(8'h00);
      end
      c = ~c;
      exp_upd += p.size();
      for (int j = 0; j < 4; j++) begin
         expq.push_back(c[31-8*j -: 8]);
         explast.push_back(8'(j == 3));
      end
   endtask

   task automatic run_frames(input string tag, input int d, input bq_t dat,
                             input bq_t lm, input bit gaps, input bit tog,
                             input int nfr);
      int i, cyc, nl;
      i = 0;
      cyc = 0;
      nl = 0;
      outq.delete();
      lastq.delete();
      strt_cyc.delete();
      last_cyc.delete();
      upd_cnt = 0;
      upd_bad = 0;
      while (nl < nfr && cyc < 4000) begin
         @(posedge clk);
         #1;
         sv[d] = (i < dat.size()) && !(gaps && $urandom_range(0, 3) == 0);
         sd[d] = (i < dat.size()) ? dat[i] : 8'h00;
         sl[d] = (i < dat.size()) ? lm[i][0] : 1'b0;
         mr[d] = tog ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk);
         if (strt[d]) strt_cyc.push_back(cyc);
         if (upd[d]) begin
            upd_cnt++;
            if (cd[d] !== md[d]) upd_bad++;
         end
         if (sv[d] && sr[d]) i++;
         if (mv[d] && mr[d]) begin
            outq.push_back(md[d]);
            lastq.push_back({7'h0, ml[d]});
            if (ml[d]) begin
               nl++;
               last_cyc.push_back(cyc);
            end
         end
         cyc++;
      end
      sv[d] = 1'b0;
      mr[d] = 1'b1;
      check({tag, ".frames"}, nl, nfr);
   endtask

   task automatic verify(input string tag, input int nfr, input int exp_len);
      int bad, lbad;
      bad = 0;
      lbad = 0;
      check({tag, ".len"}, outq.size(), exp_len);
      foreach (expq[j]) begin
         if (j >= outq.size() || outq[j] !== expq[j]) bad++;
         if (j >= lastq.size() || lastq[j] !== explast[j]) lbad++;
      end
      check({tag, ".bytes"}, bad, 0);
      check({tag, ".last"}, lbad, 0);
      check({tag, ".upd"}, upd_cnt, exp_upd);
      check({tag, ".upd_data"}, upd_bad, 0);
      check({tag, ".strt"}, strt_cyc.size(), nfr);
   endtask

   initial begin
      vt[0] = '{0, 9, 'h31, 1'b0, 1'b0, 13, 9};
      vt[1] = '{1, 10, 'h01, 1'b0, 1'b0, 64, 60};
      vt[2] = '{1, 64, 'h00, 1'b1, 1'b1, 68, 64};
      vt[3] = '{0, 1, 'hFF, 1'b0, 1'b0, 5, 1};
      vt[4] = '{1, 1, 'hFF, 1'b0, 1'b0, 64, 60};
      vt[5] = '{1, 59, 'h10, 1'b0, 1'b1, 64, 60};
      vt[6] = '{1, 60, 'h20, 1'b1, 1'b0, 64, 60};
      vt[7] = '{0, 61, 'h40, 1'b0, 1'b0, 65, 61};

      rst = 1'b1;
      sv = '0;
      sl = '0;
      mr = '0;
      sd[0] = '0;
      sd[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", {mv, ml, sr, strt, upd, busy, md[0], md[1], cd[0], cd[1]}, 0);
      rst = 1'b0;

      for (int r = 0; r < 8; r++) begin
         dq.delete();
         lq.delete();
         expq.delete();
         explast.delete();
         exp_upd = 0;
         for (int j = 0; j < vt[r].len; j++) begin
            dq.push_back(8'(vt[r].first + j));
            lq.push_back(8'(j == vt[r].len - 1));
         end
         add_frame(vt[r].d, dq);
         run_frames($sformatf("r%0d", r), vt[r].d, dq, lq, vt[r].gaps, vt[r].tog, 1);
         verify($sformatf("r%0d", r), 1, vt[r].exp_len);
         check($sformatf("r%0d.upd_hand", r), upd_cnt, vt[r].exp_upd);
         if (r == 0 && outq.size() >= 13)
            check("r0.fcs_check", {outq[9], outq[10], outq[11], outq[12]}, 32'hCBF43926);
      end

      // two 60-byte frames with s_valid held high across the boundary
      dq.delete();
      lq.delete();
      expq.delete();
      explast.delete();
      exp_upd = 0;
      begin
         bq_t f1, f2;
         for (int j = 0; j < 60; j++) begin
            f1.push_back(8'(j));
            f2.push_back(8'(3 * j + 7));
            lq.push_back(8'(j == 59));
         end
         for (int j = 0; j < 60; j++) lq.push_back(8'(j == 59));
         dq = f1;
         foreach (f2[j]) dq.push_back(f2[j]);
         add_frame(0, f1);
         add_frame(0, f2);
      end
      run_frames("b2b", 0, dq, lq, 1'b0, 1'b0, 2);
      verify("b2b", 2, 128);
      if (strt_cyc.size() == 2 && last_cyc.size() == 2)
         check("b2b.gap", strt_cyc[1] - last_cyc[0], 2);
      else
         check("b2b.events", strt_cyc.size() + last_cyc.size(), 4);

      // reset pulse on the first FCS byte, then a fresh 1-byte frame
      begin
         int cyc;
         bit got, acc;
         cyc = 0;
         got = 1'b0;
         acc = 1'b0;
         while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            sv[0] = !acc;
            sd[0] = 8'hAA;
            sl[0] = 1'b1;
            mr[0] = 1'b1;
            @(negedge clk);
            if (sv[0] && sr[0]) acc = 1'b1;
            else if (acc && mv[0]) got = 1'b1;
            cyc++;
         end
         check("rst.reached_fcs", got, 1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         check("rst.outs", {mv[0], ml[0], sr[0], strt[0], upd[0], busy[0], md[0], cd[0]}, 0);
      end
      dq.delete();
      lq.delete();
      expq.delete();
      explast.delete();
      exp_upd = 0;
      dq.push_back(8'h5A);
      lq.push_back(8'h01);
      add_frame(0, dq);
      run_frames("post_rst", 0, dq, lq, 1'b0, 1'b0, 1);
      verify("post_rst", 1, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
